spi_master: RTL

SPI bus initiator that generates SPI_SS, SPI_CLK and SPI_MOSI from a byte stream and captures SPI_MISO into received bytes. It is the on-chip counterpart of `spiifc`: it drives that slave, or an external one, using the same mode (clock idle low, MOSI launched on falling edge, sampled on rising edge, MSB first). The whole block runs on SysClk. Bytes are framed into transactions by a `txLast` flag; SPI_SS stays low across consecutive bytes of one transaction.

---
 rtl/spi_master.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: SPI bus initiator with clock idle low, MOSI launched on the
// falling SPI_CLK edge, MISO sampled on the rising edge, MSB first.
// Bytes arrive through a one-entry holding register; txLast closes a
// transaction, and SPI_SS stays low across the bytes of one transaction.
// Optional build macro SPI_MASTER_DEBUG_EN adds a registered debug_out port
// carrying {state, bitCount, holdFull}.
module spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned SS_GAP  = 2
) (
  input  logic       SysClk,
  input  logic       Reset,
  input  logic [7:0] txData,
  input  logic       txLast,
  input  logic       txValid,
  output logic       txReady,
  output logic [7:0] rcData,
  output logic       rcValid,
  output logic       busy,
`ifdef SPI_MASTER_DEBUG_EN
  output logic [7:0] debug_out,
`endif
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_SS
);

  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);
  localparam logic [31:0] GAP_LAST = 32'(SS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_STALL = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        clk_q, clk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        last_q, last_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_last_q, hold_last_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  rc_data_q, rc_data_d;
  logic        rc_valid_q, rc_valid_d;
  logic        load_shifter;
  logic        tx_accept;

  assign tx_accept = txValid & ~hold_full_q;

  // Sequencer: half-period timing, serial clock/data generation and framing
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    clk_d        = clk_q;
    mosi_d       = mosi_q;
    ss_d         = ss_q;
    shift_d      = shift_q;
    rx_d         = rx_q;
    last_d       = last_q;
    rc_data_d    = rc_data_q;
    rc_valid_d   = 1'b0;
    load_shifter = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load_shifter = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!clk_q) begin
            // Rising edge: capture MISO, the 8th capture completes the byte
            clk_d     = 1'b1;
            rx_d      = {rx_q[6:0], SPI_MISO};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rc_valid_d = 1'b1;
              rc_data_d  = {rx_q[6:0], SPI_MISO};
            end
          end else begin
            // Falling edge: either launch the next bit or close the byte
            clk_d = 1'b0;
            if (bit_cnt_q == 4'd8) begin
              if (last_q) begin
                state_d = ST_HOLD;
              end else if (hold_full_q) begin
                load_shifter = 1'b1;
              end else begin
                state_d = ST_STALL;
              end
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              mosi_d  = shift_q[6];
            end
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_STALL: begin
        if (hold_full_q) begin
          load_shifter = 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_GAP: begin
        // The final gap cycle doubles as the idle decision so a queued
        // transaction follows after exactly SS_GAP high cycles.
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (hold_full_q) begin
            load_shifter = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_shifter) begin
      state_d   = ST_SHIFT;
      shift_d   = hold_data_q;
      last_d    = hold_last_q;
      mosi_d    = hold_data_q[7];
      ss_d      = 1'b0;
      clk_d     = 1'b0;
      cnt_d     = '0;
      bit_cnt_d = 4'd0;
      rx_d      = 8'h00;
    end
  end

  // Holding register: accepts only while empty, drains when the shifter loads
  always_comb begin
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    if (tx_accept) begin
      hold_data_d = txData;
      hold_last_d = txLast;
      hold_full_d = 1'b1;
    end
    if (load_shifter) begin
      hold_full_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 4'd0;
      clk_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      shift_q     <= 8'h00;
      rx_q        <= 8'h00;
      last_q      <= 1'b0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      rc_data_q   <= 8'h00;
      rc_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      clk_q       <= clk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      rc_data_q   <= rc_data_d;
      rc_valid_q  <= rc_valid_d;
    end
  end

`ifdef SPI_MASTER_DEBUG_EN
  logic [7:0] debug_q, debug_d;

  // Debug snapshot of sequencer state, bits captured and holding occupancy
  always_comb begin
    debug_d = {state_q, bit_cnt_q, hold_full_q};
  end

  // Debug register, cleared with the rest of the block
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      debug_q <= 8'h00;
    end else begin
      debug_q <= debug_d;
    end
  end

  assign debug_out = debug_q;
`endif

  assign txReady  = ~hold_full_q;
  assign rcData   = rc_data_q;
  assign rcValid  = rc_valid_q;
  assign busy     = (state_q != ST_IDLE) | hold_full_q;
  assign SPI_CLK  = clk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_SS   = ss_q;

endmodule
